relu_maxpool_row: RTL and testbench

- Streaming post-convolution stage directly downstream of the convolution accelerator.
- Accepts one 26-element row of 16-bit conv results per handshake and applies ReLU.
- Performs 2x2/stride-2 max pooling, requantizes to 8 bits, and emits one 13-element pooled row per pair of input rows.
- Produces a 13x13 8-bit feature map per 26x26 frame for the next layer.

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/relu_maxpool_row_if.sv | 24 ++
 rtl/pool4_requant.sv | 29 ++
 rtl/relu_maxpool_row.sv | 109 ++++++++++
 tb/tb_relu_maxpool_row.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants, row types and FSM encoding for the ReLU/max-pool stage
package cnn_pkg;

  localparam int CONV_OUT_DIM = 26;
  localparam int POOL_OUT_DIM = 13;
  localparam int CONV_W       = 16;
  localparam int ACT_W        = 8;

  localparam int ROW_W = CONV_OUT_DIM;
  localparam int ROWS  = 26;
  localparam int IN_W  = CONV_W;
  localparam int OUT_W = ACT_W;
  localparam int SHIFT = 4;
  localparam int IDX_W = 5;

  typedef logic [CONV_W-1:0] conv_row_t [0:CONV_OUT_DIM-1];
  typedef logic [ACT_W-1:0]  pool_row_t [0:POOL_OUT_DIM-1];

  typedef enum logic [1:0] {S_EVEN, S_ODD, S_OUT} pool_state_e;

  function automatic logic [CONV_W-1:0] relu(input logic [CONV_W-1:0] x);
    return x[CONV_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/relu_maxpool_row_if.sv
// rtl/relu_maxpool_row_if.sv - row-in / pooled-row-out handshake bundle
interface relu_maxpool_row_if;
  import cnn_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  conv_row_t            in_row;
  logic                 out_valid;
  logic                 out_ready;
  pool_row_t            out_row;
  logic [IDX_W-1:0]     out_row_idx;
  logic                 frame_done;

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx, frame_done
  );

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_row, out_row_idx, frame_done
  );

endinterface

// File: rtl/pool4_requant.sv
// rtl/pool4_requant.sv - 4-input unsigned max followed by shift and saturate
module pool4_requant
  import cnn_pkg::*;
#(
  parameter int P_IN_W  = CONV_W,
  parameter int P_OUT_W = ACT_W,
  parameter int P_SHIFT = SHIFT
) (
  input  logic [P_IN_W-1:0]  a_i,
  input  logic [P_IN_W-1:0]  b_i,
  input  logic [P_IN_W-1:0]  c_i,
  input  logic [P_IN_W-1:0]  d_i,
  output logic [P_OUT_W-1:0] q_o
);

  logic [P_IN_W-1:0] m_ab;
  logic [P_IN_W-1:0] m_cd;
  logic [P_IN_W-1:0] m_all;
  logic [P_IN_W-1:0] shifted;

  assign m_ab  = (a_i > b_i) ? a_i : b_i;
  assign m_cd  = (c_i > d_i) ? c_i : d_i;
  assign m_all = (m_ab > m_cd) ? m_ab : m_cd;

  // Inputs are post-ReLU so the sign bit is clear; a logical shift equals the arithmetic one.
  assign shifted = m_all >> P_SHIFT;
  assign q_o     = (|shifted[P_IN_W-1:P_OUT_W]) ? {P_OUT_W{1'b1}} : shifted[P_OUT_W-1:0];

endmodule

// File: rtl/relu_maxpool_row.sv
// rtl/relu_maxpool_row.sv - ReLU + 2x2/stride-2 max pool + requant, one pooled row per input row pair
module relu_maxpool_row
  import cnn_pkg::*;
(
  input logic               clk,
  input logic               reset,
  relu_maxpool_row_if.slave bus
);

  pool_state_e       state_q, state_d;
  logic [IDX_W-1:0]  pair_cnt_q, pair_cnt_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_done_q, frame_done_d;
  conv_row_t         line_q, line_d;
  pool_row_t         out_row_q, out_row_d;

  conv_row_t         relu_row;
  pool_row_t         pooled;
  logic              in_ready;
  logic              in_fire, out_fire, last_pair;
  logic              load_line, load_out, out_done;

  always_comb begin
    for (int i = 0; i < ROW_W; i++) relu_row[i] = relu(bus.in_row[i]);
  end

  // Odd row is never stored: it is pooled straight against the buffered even row.
  for (genvar k = 0; k < ROW_W/2; k++) begin : g_pool
    pool4_requant u_pool (
      .a_i (line_q[2*k]),
      .b_i (line_q[2*k+1]),
      .c_i (relu_row[2*k]),
      .d_i (relu_row[2*k+1]),
      .q_o (pooled[k])
    );
  end

  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = out_valid_q && bus.out_ready;
  assign last_pair = (pair_cnt_q == IDX_W'(ROWS/2 - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_EVEN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EVEN:  if (in_fire)  state_d = S_ODD;
      S_ODD:   if (in_fire)  state_d = S_OUT;
      S_OUT:   if (out_fire) state_d = S_EVEN;
      default:               state_d = S_EVEN;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != S_OUT);
    load_line = (state_q == S_EVEN) && in_fire;
    load_out  = (state_q == S_ODD)  && in_fire;
    out_done  = (state_q == S_OUT)  && out_fire;
  end

  always_comb begin
    line_d       = line_q;
    out_row_d    = out_row_q;
    out_idx_d    = out_idx_q;
    out_valid_d  = out_valid_q;
    pair_cnt_d   = pair_cnt_q;
    frame_done_d = 1'b0;
    if (load_line) line_d = relu_row;
    if (load_out) begin
      out_row_d   = pooled;
      out_idx_d   = pair_cnt_q;
      out_valid_d = 1'b1;
    end
    if (out_done) begin
      out_valid_d  = 1'b0;
      frame_done_d = last_pair;
      pair_cnt_d   = last_pair ? '0 : pair_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pair_cnt_q   <= '0;
      out_idx_q    <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < ROW_W; i++)   line_q[i]    <= '0;
      for (int k = 0; k < ROW_W/2; k++) out_row_q[k] <= '0;
    end else begin
      pair_cnt_q   <= pair_cnt_d;
      out_idx_q    <= out_idx_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      line_q       <= line_d;
      out_row_q    <= out_row_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_row     = out_row_q;
  assign bus.out_row_idx = out_idx_q;
  assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool_row.sv
// tb/tb_relu_maxpool_row.sv - self-checking bench for relu_maxpool_row
module tb_relu_maxpool_row;
  import cnn_pkg::*;

  typedef logic [ROW_W-1:0][IN_W-1:0]    prow_t;
  typedef logic [ROW_W/2-1:0][OUT_W-1:0] ppool_t;
  typedef struct packed {
    prow_t  even;
    prow_t  odd;
    ppool_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  relu_maxpool_row_if bus ();

  relu_maxpool_row dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic ppool_t get_out();
    ppool_t p;
    for (int k = 0; k < ROW_W/2; k++) p[k] = bus.out_row[k];
    return p;
  endfunction

  task automatic chk_row(input string name, input ppool_t exp);
    ppool_t got;
    got = get_out();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: ReLU, max of the 2x2 window, divide by 16, clamp to 255.
  function automatic ppool_t model(input prow_t e, input prow_t o);
    ppool_t p;
    for (int k = 0; k < ROW_W/2; k++) begin
      int cand[4];
      int m;
      cand[0] = int'(e[2*k]);
      cand[1] = int'(e[2*k+1]);
      cand[2] = int'(o[2*k]);
      cand[3] = int'(o[2*k+1]);
      m = 0;
      for (int j = 0; j < 4; j++) begin
        if (cand[j] >= 32768) cand[j] = 0;
        if (cand[j] > m) m = cand[j];
      end
      m = m / 16;
      if (m > 255) m = 255;
      p[k] = 8'(m);
    end
    return p;
  endfunction

  function automatic prow_t rand_row();
    prow_t r;
    for (int i = 0; i < ROW_W; i++) begin
      case ($urandom_range(0, 3))
        0:       r[i] = 16'($urandom);
        1:       r[i] = 16'($urandom_range(0, 4095));
        2:       r[i] = 16'($urandom_range(32768, 65535));
        default: r[i] = 16'($urandom_range(0, 600));
      endcase
    end
    return r;
  endfunction

  task automatic drive_row(input prow_t r);
    for (int i = 0; i < ROW_W; i++) bus.in_row[i] = r[i];
  endtask

  task automatic send_row(input string name, input prow_t r);
    bit ok;
    logic rdy;
    ok = 0;
    drive_row(r);
    bus.in_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s in_ready timeout got 0 expected 1", name);
    end
  endtask

  task automatic accept_out(input string name, input bit rnd);
    bit ok;
    logic v, r;
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      v = bus.out_valid;
      r = bus.out_ready;
      @(posedge clk);
      #1;
      if (v && r) ok = 1;
    end
    bus.out_ready = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s out_valid timeout got 0 expected 1", name);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    chk("rst_async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_async_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  vec_t   tbl[6];
  prow_t  e, o;
  ppool_t exp_p, snap;
  logic [IDX_W-1:0] snap_idx;
  bit     stable;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_row('0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_idx", 32'(bus.out_row_idx), 32'd0);
    chk_row("rst_row", '0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < ROW_W; i++) begin
      tbl[0].even[i] = 16'd32;
      tbl[0].odd[i]  = (i % 2 == 0) ? 16'd160 : 16'd16;
      tbl[1].even[i] = (i % 2 == 0) ? 16'hFF00 : 16'h7FFF;
      tbl[1].odd[i]  = 16'hFFFF;
      tbl[2].even[i] = 16'h8000;
      tbl[2].odd[i]  = 16'hFFFF;
      tbl[3].even[i] = 16'h000F;
      tbl[3].odd[i]  = 16'h001F;
    end
    for (int k = 0; k < ROW_W/2; k++) begin
      tbl[0].exp[k] = 8'd10;
      tbl[1].exp[k] = 8'd255;
      tbl[2].exp[k] = 8'd0;
      tbl[3].exp[k] = 8'd1;
    end
    for (int i = 4; i < 6; i++) begin
      tbl[i].even = rand_row();
      tbl[i].odd  = rand_row();
      tbl[i].exp  = model(tbl[i].even, tbl[i].odd);
    end

    for (int i = 0; i < 6; i++) begin
      send_row("tbl_even", tbl[i].even);
      chk("tbl_valid_before_odd", 32'(bus.out_valid), 32'd0);
      send_row("tbl_odd", tbl[i].odd);
      chk("tbl_valid_latency", 32'(bus.out_valid), 32'd1);
      chk("tbl_in_ready_out", 32'(bus.in_ready), 32'd0);
      chk_row("tbl_row", tbl[i].exp);
      chk("tbl_idx", 32'(bus.out_row_idx), 32'(i));
      accept_out("tbl_accept", 1'b0);
      chk("tbl_valid_after", 32'(bus.out_valid), 32'd0);
    end

    // Backpressure: pair index 6, junk offered on the input while stalled
    e = rand_row();
    o = rand_row();
    send_row("bp_even", e);
    send_row("bp_odd", o);
    snap = get_out();
    snap_idx = bus.out_row_idx;
    bus.out_ready = 1'b0;
    drive_row(rand_row());
    bus.in_valid = 1'b1;
    stable = 1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          get_out() !== snap || bus.out_row_idx !== snap_idx) stable = 0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    chk_row("bp_row", model(e, o));
    chk("bp_idx", 32'(bus.out_row_idx), 32'd6);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_valid_after", 32'(bus.out_valid), 32'd0);
    chk("bp_ready_after", 32'(bus.in_ready), 32'd1);

    // Gap between even and odd rows, with a stray out_ready while nothing is valid
    e = rand_row();
    o = rand_row();
    send_row("gap_even", e);
    stable = 1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      drive_row(rand_row());
      @(posedge clk);
      #1;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) stable = 0;
    end
    bus.out_ready = 1'b0;
    chk("gap_idle", 32'(stable), 32'd1);
    send_row("gap_odd", o);
    chk_row("gap_row", model(e, o));
    chk("gap_idx", 32'(bus.out_row_idx), 32'd7);
    accept_out("gap_accept", 1'b0);

    // Reset between an even and an odd row
    for (int i = 0; i < ROW_W; i++) e[i] = 16'h7FFF;
    send_row("rmid_even", e);
    do_reset();
    chk("rmid_valid", 32'(bus.out_valid), 32'd0);
    chk("rmid_ready", 32'(bus.in_ready), 32'd1);
    e = rand_row();
    o = rand_row();
    send_row("rmid_even2", e);
    send_row("rmid_odd2", o);
    chk_row("rmid_row", model(e, o));
    chk("rmid_idx", 32'(bus.out_row_idx), 32'd0);
    accept_out("rmid_accept", 1'b0);

    // Full frame with random out_ready
    do_reset();
    for (int p = 0; p < ROWS/2; p++) begin
      e = rand_row();
      o = rand_row();
      exp_p = model(e, o);
      send_row("frm_even", e);
      send_row("frm_odd", o);
      chk_row("frm_row", exp_p);
      chk("frm_idx", 32'(bus.out_row_idx), 32'(p));
      accept_out("frm_accept", 1'b1);
      chk("frm_done", 32'(bus.frame_done), (p == ROWS/2 - 1) ? 32'd1 : 32'd0);
      if (p == ROWS/2 - 1) begin
        @(posedge clk);
        #1;
        chk("frm_done_pulse", 32'(bus.frame_done), 32'd0);
      end
    end
    e = rand_row();
    o = rand_row();
    send_row("nxt_even", e);
    send_row("nxt_odd", o);
    chk_row("nxt_row", model(e, o));
    chk("nxt_idx", 32'(bus.out_row_idx), 32'd0);
    accept_out("nxt_accept", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
